// File: rtl/axil_pkg.sv
// Shared AXI4-lite definitions for the CPU memory-bus slaves: response codes,
// bus widths and the state encodings used by the RAM responder.
package axil_pkg;

  localparam int unsigned AXIL_ADDR_W = 32;
  localparam int unsigned AXIL_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // off is the byte offset from the window base, already wrapped at 32 bits
  function automatic logic word_in_window(input logic [AXIL_ADDR_W-1:0] off,
                                          input logic [AXIL_ADDR_W-1:0] words);
    return (off >> 2) < words;
  endfunction

endpackage

// File: rtl/ram_1w1r_be.sv
// WORDS x 32 RAM with one byte-enabled write port and one synchronous read port.
// A read and write to the same word on the same edge return the old contents.
module ram_1w1r_be
  import axil_pkg::*;
#(
  parameter int unsigned WORDS = 1024,
  parameter int unsigned IDX_W = $clog2(WORDS)
) (
  input  logic                   clk,
  input  logic                   we_i,
  input  logic [3:0]             be_i,
  input  logic [IDX_W-1:0]       waddr_i,
  input  logic [AXIL_DATA_W-1:0] wdata_i,
  input  logic                   re_i,
  input  logic [IDX_W-1:0]       raddr_i,
  output logic [AXIL_DATA_W-1:0] rdata_o
);

  logic [AXIL_DATA_W-1:0] mem_q [WORDS];
  logic [AXIL_DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i && be_i[i]) begin
        mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axil_ram_slave.sv
// AXI4-lite RAM responder for the CPU memory bus: independent write and read
// FSMs in front of a byte-writable RAM, out-of-window accesses answer SLVERR.
//
//  state  | meaning
//  W_IDLE | collecting AW and W; each handshake latched independently
//  W_RESP | write committed (or rejected), bvalid high until bready
//  R_IDLE | arready high, RAM read on the AR handshake edge
//  R_DATA | rvalid high with rdata/rresp held until rready
module axil_ram_slave
  import axil_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rsi_reset,
  input  logic        axs_awvalid,
  output logic        axs_awready,
  input  logic [31:0] axs_awaddr,
  input  logic [2:0]  axs_awprot,
  input  logic        axs_wvalid,
  output logic        axs_wready,
  input  logic [31:0] axs_wdata,
  input  logic [3:0]  axs_wstrb,
  output logic        axs_bvalid,
  output logic [1:0]  axs_bresp,
  input  logic        axs_bready,
  input  logic        axs_arvalid,
  output logic        axs_arready,
  input  logic [31:0] axs_araddr,
  input  logic [2:0]  axs_arprot,
  output logic        axs_rvalid,
  output logic [1:0]  axs_rresp,
  output logic [31:0] axs_rdata,
  input  logic        axs_rready
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam logic [31:0] WORDS = 32'(MEM_WORDS);

  wr_state_e   w_state_q, w_state_d;
  logic        aw_held_q, aw_held_d;
  logic        w_held_q, w_held_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  bresp_q, bresp_d;

  rd_state_e   r_state_q, r_state_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rd_ok_q, rd_ok_d;

  logic        aw_rdy, w_rdy, ar_rdy;
  logic        aw_fire, w_fire, ar_fire;
  logic        aw_have, w_have;
  logic [31:0] wr_addr, wr_data, wr_off, rd_off;
  logic [3:0]  wr_strb;
  logic        wr_in, rd_in;
  logic        ram_we, ram_re;
  logic [31:0] ram_rdata;
  logic        unused_ok;

  // Readies and valids depend only on local state and reset, never on master readies
  assign aw_rdy  = !rsi_reset && (w_state_q == W_IDLE) && !aw_held_q;
  assign w_rdy   = !rsi_reset && (w_state_q == W_IDLE) && !w_held_q;
  assign ar_rdy  = !rsi_reset && (r_state_q == R_IDLE);
  assign aw_fire = axs_awvalid && aw_rdy;
  assign w_fire  = axs_wvalid && w_rdy;
  assign ar_fire = axs_arvalid && ar_rdy;
  assign aw_have = aw_held_q || aw_fire;
  assign w_have  = w_held_q || w_fire;

  // A same-cycle handshake bypasses the holding registers
  assign wr_addr = aw_held_q ? awaddr_q : axs_awaddr;
  assign wr_data = w_held_q ? wdata_q : axs_wdata;
  assign wr_strb = w_held_q ? wstrb_q : axs_wstrb;
  assign wr_off  = wr_addr - BASE_ADDR;
  assign rd_off  = axs_araddr - BASE_ADDR;
  assign wr_in   = word_in_window(wr_off, WORDS);
  assign rd_in   = word_in_window(rd_off, WORDS);

  assign unused_ok = ^{axs_awprot, axs_arprot, wr_off[1:0], rd_off[1:0]};

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    ram_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_fire) begin
          aw_held_d = 1'b1;
          awaddr_d  = axs_awaddr;
        end
        if (w_fire) begin
          w_held_d = 1'b1;
          wdata_d  = axs_wdata;
          wstrb_d  = axs_wstrb;
        end
        if (aw_have && w_have) begin
          ram_we    = wr_in;
          bresp_d   = wr_in ? RESP_OKAY : RESP_SLVERR;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (axs_bready) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    if (rsi_reset) begin
      ram_we = 1'b0;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    rresp_d   = rresp_q;
    rd_ok_d   = rd_ok_q;
    ram_re    = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (ar_fire) begin
          ram_re    = rd_in;
          rd_ok_d   = rd_in;
          rresp_d   = rd_in ? RESP_OKAY : RESP_SLVERR;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (axs_rready) begin
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rsi_reset) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      rresp_q   <= RESP_OKAY;
      rd_ok_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      rresp_q   <= rresp_d;
      rd_ok_q   <= rd_ok_d;
    end
  end

  ram_1w1r_be #(
    .WORDS (MEM_WORDS),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .be_i    (wr_strb),
    .waddr_i (wr_off[IDX_W+1:2]),
    .wdata_i (wr_data),
    .re_i    (ram_re),
    .raddr_i (rd_off[IDX_W+1:2]),
    .rdata_o (ram_rdata)
  );

  assign axs_awready = aw_rdy;
  assign axs_wready  = w_rdy;
  assign axs_arready = ar_rdy;
  assign axs_bvalid  = !rsi_reset && (w_state_q == W_RESP);
  assign axs_rvalid  = !rsi_reset && (r_state_q == R_DATA);
  assign axs_bresp   = rsi_reset ? 2'b00 : bresp_q;
  assign axs_rresp   = rsi_reset ? 2'b00 : rresp_q;
  assign axs_rdata   = (!rsi_reset && rd_ok_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_axil_ram_slave.sv
// Scoreboard bench for axil_ram_slave: expected B/R responses are queued as
// transactions are driven and compared when the slave presents them.
module tb_axil_ram_slave;

  localparam int unsigned MEM_WORDS = 1024;
  localparam logic [31:0] BASE      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rsi_reset;
  logic        axs_awvalid, axs_awready;
  logic [31:0] axs_awaddr;
  logic [2:0]  axs_awprot;
  logic        axs_wvalid, axs_wready;
  logic [31:0] axs_wdata;
  logic [3:0]  axs_wstrb;
  logic        axs_bvalid;
  logic [1:0]  axs_bresp;
  logic        axs_bready;
  logic        axs_arvalid, axs_arready;
  logic [31:0] axs_araddr;
  logic [2:0]  axs_arprot;
  logic        axs_rvalid;
  logic [1:0]  axs_rresp;
  logic [31:0] axs_rdata;
  logic        axs_rready;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_bresp [$];
  logic [31:0] exp_rdata [$];
  logic [31:0] exp_rresp [$];
  logic [31:0] model [int];

  always #5 clk = ~clk;

  axil_ram_slave #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rsi_reset(rsi_reset),
    .axs_awvalid(axs_awvalid), .axs_awready(axs_awready), .axs_awaddr(axs_awaddr),
    .axs_awprot(axs_awprot),
    .axs_wvalid(axs_wvalid), .axs_wready(axs_wready), .axs_wdata(axs_wdata),
    .axs_wstrb(axs_wstrb),
    .axs_bvalid(axs_bvalid), .axs_bresp(axs_bresp), .axs_bready(axs_bready),
    .axs_arvalid(axs_arvalid), .axs_arready(axs_arready), .axs_araddr(axs_araddr),
    .axs_arprot(axs_arprot),
    .axs_rvalid(axs_rvalid), .axs_rresp(axs_rresp), .axs_rdata(axs_rdata),
    .axs_rready(axs_rready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic in_win(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return (off >> 2) < MEM_WORDS;
  endfunction

  function automatic int widx(input logic [31:0] addr);
    logic [31:0] off;
    off = (addr - BASE) >> 2;
    return int'(off);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] addr);
    if (!in_win(addr)) return 32'h0;
    if (model.exists(widx(addr))) return model[widx(addr)];
    return 32'h0;
  endfunction

  task automatic model_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] m;
    if (!in_win(addr)) return;
    m = model_rd(addr);
    for (int i = 0; i < 4; i++) if (strb[i]) m[8*i +: 8] = data[8*i +: 8];
    model[widx(addr)] = m;
  endtask

  // Scoreboard side: pop on the cycle a response handshake is about to complete
  always @(negedge clk) begin
    if (!rsi_reset && axs_bvalid && axs_bready) begin
      if (exp_bresp.size() == 0) check_eq("b_unexpected", 32'h1, 32'h0);
      else check_eq("bresp", {30'h0, axs_bresp}, exp_bresp.pop_front());
    end
    if (!rsi_reset && axs_rvalid && axs_rready) begin
      if (exp_rdata.size() == 0) check_eq("r_unexpected", 32'h1, 32'h0);
      else begin
        check_eq("rdata", axs_rdata, exp_rdata.pop_front());
        check_eq("rresp", {30'h0, axs_rresp}, exp_rresp.pop_front());
      end
    end
  end

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, input int b_hold);
    logic ok;
    logic [31:0] eb;
    eb = in_win(addr) ? 32'h0 : 32'h2;
    exp_bresp.push_back(eb);
    model_wr(addr, data, strb);
    axs_wvalid = 1'b1; axs_wdata = data; axs_wstrb = strb; axs_awaddr = addr;
    if (w_lead > 0) begin
      @(negedge clk);
      check_eq("wready_idle", {31'h0, axs_wready}, 32'h1);
      @(posedge clk); #1;
      axs_wvalid = 1'b0;
      check_eq("wready_held", {31'h0, axs_wready}, 32'h0);
      check_eq("bvalid_early", {31'h0, axs_bvalid}, 32'h0);
      repeat (w_lead - 1) begin @(posedge clk); #1; end
    end
    axs_awvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (axs_awready) begin ok = 1'b1; break; end
    end
    if (!ok) check_eq("aw_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    axs_awvalid = 1'b0; axs_wvalid = 1'b0;
    check_eq("bvalid_t1", {31'h0, axs_bvalid}, 32'h1);
    for (int k = 0; k < b_hold; k++) begin
      @(posedge clk); #1;
      check_eq("bvalid_hold", {31'h0, axs_bvalid}, 32'h1);
      check_eq("bresp_hold", {30'h0, axs_bresp}, eb);
    end
    axs_bready = 1'b1;
    @(posedge clk); #1;
    axs_bready = 1'b0;
    check_eq("bvalid_drop", {31'h0, axs_bvalid}, 32'h0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int r_hold);
    logic ok;
    exp_rdata.push_back(model_rd(addr));
    exp_rresp.push_back(in_win(addr) ? 32'h0 : 32'h2);
    axs_arvalid = 1'b1; axs_araddr = addr;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (axs_arready) begin ok = 1'b1; break; end
    end
    if (!ok) check_eq("ar_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    axs_arvalid = 1'b0;
    check_eq("rvalid_lat1", {31'h0, axs_rvalid}, 32'h1);
    check_eq("arready_busy", {31'h0, axs_arready}, 32'h0);
    for (int k = 0; k < r_hold; k++) begin
      @(posedge clk); #1;
      check_eq("rvalid_hold", {31'h0, axs_rvalid}, 32'h1);
      check_eq("rdata_hold", axs_rdata, exp_rdata[0]);
    end
    axs_rready = 1'b1;
    @(posedge clk); #1;
    axs_rready = 1'b0;
    check_eq("rvalid_drop", {31'h0, axs_rvalid}, 32'h0);
    check_eq("arready_back", {31'h0, axs_arready}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic [3:0]  s;
    rsi_reset = 1'b1;
    axs_awvalid = 0; axs_awaddr = 0; axs_awprot = 0;
    axs_wvalid = 0; axs_wdata = 0; axs_wstrb = 0; axs_bready = 0;
    axs_arvalid = 0; axs_araddr = 0; axs_arprot = 0; axs_rready = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_awready", {31'h0, axs_awready}, 32'h0);
    check_eq("rst_wready", {31'h0, axs_wready}, 32'h0);
    check_eq("rst_arready", {31'h0, axs_arready}, 32'h0);
    check_eq("rst_bvalid", {31'h0, axs_bvalid}, 32'h0);
    check_eq("rst_rvalid", {31'h0, axs_rvalid}, 32'h0);
    check_eq("rst_rdata", axs_rdata, 32'h0);
    rsi_reset = 1'b0;
    @(posedge clk); #1;
    check_eq("post_awready", {31'h0, axs_awready}, 32'h1);
    check_eq("post_wready", {31'h0, axs_wready}, 32'h1);
    check_eq("post_arready", {31'h0, axs_arready}, 32'h1);

    axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0);
    axi_read(32'h10, 0);
    axi_write(32'h14, 32'hCAFE_F00D, 4'hF, 3, 5);
    axi_read(32'h14, 2);
    axi_write(32'h10, 32'h0000_00AA, 4'b0001, 0, 0);
    axi_read(32'h10, 0);
    axi_write(32'h10, 32'hFFFF_FFFF, 4'b0000, 1, 0);
    axi_read(32'h10, 1);

    axi_write(32'h0, 32'h0BAD_CAFE, 4'hF, 0, 0);
    axi_write(32'h0000_1000, 32'h5555_5555, 4'hF, 0, 2);
    axi_read(32'h0, 0);
    axi_read(32'h0000_1000, 1);
    axi_read(32'hFFFF_FFFC, 0);
    axi_read(32'h0000_0FFC, 0);

    // Write commit and AR to the same word on the same edge
    axi_write(32'h20, 32'h0, 4'hF, 0, 0);
    exp_bresp.push_back(32'h0);
    exp_rdata.push_back(model_rd(32'h20));
    exp_rresp.push_back(32'h0);
    model_wr(32'h20, 32'h1234_5678, 4'hF);
    axs_awvalid = 1; axs_awaddr = 32'h20; axs_wvalid = 1; axs_wdata = 32'h1234_5678;
    axs_wstrb = 4'hF; axs_arvalid = 1; axs_araddr = 32'h20;
    @(posedge clk); #1;
    axs_awvalid = 0; axs_wvalid = 0; axs_arvalid = 0;
    check_eq("coll_bvalid", {31'h0, axs_bvalid}, 32'h1);
    check_eq("coll_rvalid", {31'h0, axs_rvalid}, 32'h1);
    axs_bready = 1; axs_rready = 1;
    @(posedge clk); #1;
    axs_bready = 0; axs_rready = 0;
    axi_read(32'h20, 0);

    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      axi_write(32'h40 + 32'(i * 4), d, 4'hF, $urandom_range(0, 2), $urandom_range(0, 2));
    end
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      axi_write(32'h40 + 32'(i * 4), d, s, $urandom_range(0, 2), $urandom_range(0, 1));
    end
    for (int i = 0; i < 6; i++) axi_read(32'h40 + 32'(i * 4), $urandom_range(0, 2));

    // Reset with both responses pending: nothing is delivered, RAM keeps its data
    model_wr(32'h30, 32'hA5A5_0F0F, 4'hF);
    axs_awvalid = 1; axs_awaddr = 32'h30; axs_wvalid = 1; axs_wdata = 32'hA5A5_0F0F;
    axs_wstrb = 4'hF; axs_arvalid = 1; axs_araddr = 32'h14;
    @(posedge clk); #1;
    axs_awvalid = 0; axs_wvalid = 0; axs_arvalid = 0;
    check_eq("pre_rst_bvalid", {31'h0, axs_bvalid}, 32'h1);
    check_eq("pre_rst_rvalid", {31'h0, axs_rvalid}, 32'h1);
    rsi_reset = 1'b1;
    @(posedge clk); #1;
    check_eq("in_rst_bvalid", {31'h0, axs_bvalid}, 32'h0);
    check_eq("in_rst_rvalid", {31'h0, axs_rvalid}, 32'h0);
    check_eq("in_rst_awready", {31'h0, axs_awready}, 32'h0);
    rsi_reset = 1'b0;
    #1;
    check_eq("rst2_bvalid", {31'h0, axs_bvalid}, 32'h0);
    check_eq("rst2_rvalid", {31'h0, axs_rvalid}, 32'h0);
    check_eq("rst2_awready", {31'h0, axs_awready}, 32'h1);
    check_eq("rst2_wready", {31'h0, axs_wready}, 32'h1);
    check_eq("rst2_arready", {31'h0, axs_arready}, 32'h1);
    check_eq("rst2_bresp", {30'h0, axs_bresp}, 32'h0);
    axi_read(32'h10, 0);
    axi_read(32'h30, 0);
    axi_read(32'h20, 0);

    repeat (3) @(posedge clk);
    check_eq("b_queue_empty", 32'(exp_bresp.size()), 32'h0);
    check_eq("r_queue_empty", 32'(exp_rdata.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
